reset_sequencer: RTL and testbench

- Ordered reset-release controller for the fabric reset tree.
- Takes the already-synchronized system reset plus PLL-lock and init-done qualifiers.
- Releases N_STAGES active-low domain resets one at a time with a fixed gap: stage 0 (interconnect), then core, then peripherals.
- Re-asserts all domains on PLL lock loss or a software reset request, then reruns the sequence.

---
 rtl/reset_seq_pkg.sv | 29 ++
 rtl/reset_sequencer.sv | 140 ++++++++++++++
 tb/tb_reset_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/reset_seq_pkg.sv
// Shared definitions for the ordered reset-release controller: state encoding,
// relock saturation limit and a parameter-legality check.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD      = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_RUN       = 2'd3
    } seq_state_e;

    localparam logic [7:0] RELOCK_MAX = 8'hFF;

    // Every timing constant has to fit in the shared counter.
    function automatic bit params_legal(input int n_stages, input int hold_cycles,
                                        input int lock_filter, input int stage_gap,
                                        input int cnt_w);
        longint lim;
        if (cnt_w < 1 || cnt_w > 32) begin
            return 1'b0;
        end
        lim = longint'(1) << cnt_w;
        return (n_stages >= 1) && (n_stages <= 8) &&
               (hold_cycles >= 1) && (lock_filter >= 1) && (stage_gap >= 1) &&
               (longint'(hold_cycles) < lim) && (longint'(lock_filter) < lim) &&
               (longint'(stage_gap) < lim);
    endfunction

endpackage

// File: rtl/reset_sequencer.sv
// Ordered reset-release controller: holds all domains, filters PLL lock/init-done,
// then releases the active-low domain resets one by one with a fixed gap.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int N_STAGES    = 3,
    parameter int HOLD_CYCLES = 8,
    parameter int LOCK_FILTER = 16,
    parameter int STAGE_GAP   = 32,
    parameter int CNT_W       = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                pll_lock,
    input  logic                init_done,
    input  logic                sw_reset_req,
    output logic [N_STAGES-1:0] stage_rst_n,
    output logic                seq_done,
    output logic [1:0]          seq_state,
    output logic [7:0]          relock_cnt
);

    localparam int IDX_W = 4;
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] FILTER_DONE = CNT_W'(LOCK_FILTER);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_STAGES - 1);

    if (!params_legal(N_STAGES, HOLD_CYCLES, LOCK_FILTER, STAGE_GAP, CNT_W)) begin : g_bad_params
        $error("reset_sequencer: illegal parameter combination");
    end

    seq_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [N_STAGES-1:0] rst_n_q, rst_n_d;
    logic                done_q, done_d;
    logic [7:0]          relock_q, relock_d;

    logic [CNT_W-1:0]    cnt_inc;
    logic                lock_lost;
    logic                lock_good;

    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign lock_good = pll_lock & init_done;
    // Only a lock drop after the first release counts as a relock event.
    assign lock_lost = ((state_q == ST_RELEASE) || (state_q == ST_RUN)) && !pll_lock;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        rst_n_d  = rst_n_q;
        done_d   = done_q;
        relock_d = relock_q;

        if (sw_reset_req || lock_lost) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            idx_d   = '0;
            rst_n_d = '0;
            done_d  = 1'b0;
            if (lock_lost && relock_q != RELOCK_MAX) begin
                relock_d = relock_q + 8'd1;
            end
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (!lock_good) begin
                        cnt_d = '0;
                    end else if (cnt_inc == FILTER_DONE) begin
                        rst_n_d[0] = 1'b1;
                        cnt_d      = '0;
                        if (N_STAGES == 1) begin
                            state_d = ST_RUN;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_RELEASE;
                            idx_d   = IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == GAP_LAST) begin
                        for (int i = 0; i < N_STAGES; i++) begin
                            if (idx_q == IDX_W'(i)) begin
                                rst_n_d[i] = 1'b1;
                            end
                        end
                        cnt_d = '0;
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_RUN;
                            done_d  = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= ST_HOLD;
            cnt_q    <= '0;
            idx_q    <= '0;
            rst_n_q  <= '0;
            done_q   <= 1'b0;
            relock_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            rst_n_q  <= rst_n_d;
            done_q   <= done_d;
            relock_q <= relock_d;
        end
    end

    assign stage_rst_n = rst_n_q;
    assign seq_done    = done_q;
    assign seq_state   = state_q;
    assign relock_cnt  = relock_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: power-up vector table, directed
// corner sequences and randomized stimulus against an edge-timeline model.
module tb_reset_sequencer;

    localparam int N  = 3;
    localparam int H  = 3;
    localparam int F  = 4;
    localparam int G  = 5;
    localparam int CW = 16;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         pll_lock = 1'b0;
    logic         init_done = 1'b0;
    logic         sw_reset_req = 1'b0;
    logic [N-1:0] stage_rst_n;
    logic         seq_done;
    logic [1:0]   seq_state;
    logic [7:0]   relock_cnt;

    reset_sequencer #(
        .N_STAGES(N), .HOLD_CYCLES(H), .LOCK_FILTER(F), .STAGE_GAP(G), .CNT_W(CW)
    ) dut (
        .clock(clock), .reset(reset), .pll_lock(pll_lock), .init_done(init_done),
        .sw_reset_req(sw_reset_req), .stage_rst_n(stage_rst_n), .seq_done(seq_done),
        .seq_state(seq_state), .relock_cnt(relock_cnt)
    );

    always #5 clock = ~clock;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int t         = 0;   // absolute edge count for the model
    int ecount    = 0;   // edge number relative to the last reset release

    // Model: the whole sequence is a timeline anchored at the edge that entered HOLD
    // (hold_e) and the edge that released stage 0 (rel_e, -1 if not yet released).
    int hold_e   = 0;
    int rel_e    = -1;
    int streak   = 0;
    int m_relock = 0;

    typedef struct {
        bit         r, p, i, s;
        logic [2:0] rst_n;
        bit         done;
        logic [1:0] st;
        logic [7:0] rl;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, ecount);
    endtask

    task automatic step(input bit r, input bit p, input bit i, input bit s);
        int exp_rst;
        int exp_done;
        int exp_state;
        reset = r; pll_lock = p; init_done = i; sw_reset_req = s;
        @(posedge clock);
        #1;
        t++;
        ecount++;
        if (!r) begin
            hold_e = t; rel_e = -1; streak = 0; m_relock = 0;
        end else if (s || (rel_e >= 0 && !p)) begin
            if (rel_e >= 0 && !p && m_relock < 255) m_relock++;
            hold_e = t; rel_e = -1; streak = 0;
        end else if (rel_e < 0 && t > hold_e + H) begin
            streak = (p && i) ? streak + 1 : 0;
            if (streak == F) rel_e = t;
        end
        exp_rst = 0;
        for (int k = 0; k < N; k++)
            if (rel_e >= 0 && t >= rel_e + k * G) exp_rst |= (1 << k);
        exp_done  = (rel_e >= 0 && t >= rel_e + (N - 1) * G) ? 1 : 0;
        exp_state = (rel_e < 0) ? ((t < hold_e + H) ? 0 : 1) : (exp_done != 0 ? 3 : 2);
        chk("model stage_rst_n", int'(stage_rst_n), exp_rst);
        chk("model seq_done", int'(seq_done), exp_done);
        chk("model seq_state", int'(seq_state), exp_state);
        chk("model relock_cnt", int'(relock_cnt), m_relock);
    endtask

    task automatic run_good(input int n);
        repeat (n) step(1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic do_reset(input int n);
        repeat (n) step(1'b0, 1'b1, 1'b1, 1'b0);
        ecount = 0;
    endtask

    initial begin
        bit r, s, p, i;
        int guard;

        // Power-up timeline with lock/init high throughout.
        vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 2'd0, 8'd0};
        for (int k = 1;  k <= 2;  k++) vecs[k] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 2'd0, 8'd0};
        for (int k = 3;  k <= 6;  k++) vecs[k] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 2'd1, 8'd0};
        for (int k = 7;  k <= 11; k++) vecs[k] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b001, 1'b0, 2'd2, 8'd0};
        for (int k = 12; k <= 16; k++) vecs[k] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b011, 1'b0, 2'd2, 8'd0};
        vecs[17] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b111, 1'b1, 2'd3, 8'd0};

        for (int k = 0; k < 18; k++) begin
            step(vecs[k].r, vecs[k].p, vecs[k].i, vecs[k].s);
            if (k == 0) ecount = 0;
            chk("vec stage_rst_n", int'(stage_rst_n), int'(vecs[k].rst_n));
            chk("vec seq_done", int'(seq_done), int'(vecs[k].done));
            chk("vec seq_state", int'(seq_state), int'(vecs[k].st));
            chk("vec relock_cnt", int'(relock_cnt), int'(vecs[k].rl));
            $display("vec edge %0d: stage_rst_n=%b seq_done=%0d seq_state=%0d", k, stage_rst_n, seq_done, seq_state);
        end

        // One-cycle lock glitch in WAIT_LOCK restarts the filter only.
        do_reset(1);
        run_good(4);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        run_good(3);
        chk("glitch edge8 stage", int'(stage_rst_n), 0);
        run_good(1);
        chk("glitch edge9 stage", int'(stage_rst_n), 1);
        chk("glitch relock", int'(relock_cnt), 0);
        $display("lock glitch: stage0 at edge %0d", ecount);

        // Lock loss in RUN.
        do_reset(1);
        run_good(29);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("runloss stage", int'(stage_rst_n), 0);
        chk("runloss done", int'(seq_done), 0);
        chk("runloss relock", int'(relock_cnt), 1);
        run_good(6);
        chk("runloss edge36 stage", int'(stage_rst_n), 0);
        run_good(1);
        chk("runloss edge37 stage", int'(stage_rst_n), 1);
        $display("run lock loss: relock_cnt=%0d stage0 back at edge %0d", relock_cnt, ecount);

        // Software reset during RELEASE.
        do_reset(1);
        run_good(9);
        chk("sw edge9 stage", int'(stage_rst_n), 1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("sw edge10 stage", int'(stage_rst_n), 0);
        chk("sw relock", int'(relock_cnt), 0);
        run_good(6);
        chk("sw edge16 stage", int'(stage_rst_n), 0);
        run_good(1);
        chk("sw edge17 stage", int'(stage_rst_n), 1);
        $display("sw reset: stage0 re-released at edge %0d", ecount);

        // Block reset mid-sequence.
        do_reset(1);
        run_good(13);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("midrst stage", int'(stage_rst_n), 0);
        chk("midrst state", int'(seq_state), 0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        run_good(6);
        chk("midrst edge21 stage", int'(stage_rst_n), 0);
        run_good(1);
        chk("midrst edge22 stage", int'(stage_rst_n), 1);
        $display("mid reset: stage0 at edge %0d", ecount);

        // Relock counter saturation.
        do_reset(1);
        for (int ev = 1; ev <= 260; ev++) begin
            guard = 0;
            while (!seq_done && guard < 100) begin
                run_good(1);
                guard++;
            end
            if (guard >= 100) chk("sat reach RUN timeout", 0, 1);
            step(1'b1, 1'b0, 1'b1, 1'b0);
            if (ev == 254) chk("sat relock at 254", int'(relock_cnt), 254);
            if (ev == 255) chk("sat relock at 255", int'(relock_cnt), 255);
        end
        chk("sat relock after 260", int'(relock_cnt), 255);
        $display("saturation: relock_cnt=%0d after 260 events", relock_cnt);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("sat cleared by reset", int'(relock_cnt), 0);

        // Randomized stimulus against the model.
        do_reset(1);
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(199) != 0);
            s = ($urandom_range(39) == 0);
            p = ($urandom_range(29) != 0);
            i = ($urandom_range(19) != 0);
            step(r, p, i, s);
        end
        $display("random: 3000 edges, final relock_cnt=%0d", relock_cnt);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
